fc_layer_pipe: RTL and testbench

Parametrised fully-connected layer with signed fixed-point data. It computes out[o] = sat(bias[o] + sum_i in[i]*w[o][i]) for every output node and supports configurable width, fraction bits and node counts. A single pipelined MAC is time-multiplexed across all products, and a start/busy/done handshake is used. It sits between convolution/pooling stages and the classifier in the accelerator datapath.

---
 rtl/fc_layer_pipe.sv | 136 +++++++++++++
 tb/tb_fc_layer_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_pipe.sv
// Fully-connected layer: out[o] = sat(bias[o] + sum_i in[i]*w[o][i]) on one time-multiplexed pipelined MAC.
// Optional macro FC_RELU_EN fuses a ReLU into the write-back of each output node.
module fc_layer_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_IN   = 5,
  parameter int N_OUT  = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [N_IN*DATA_W-1:0]         in_vec,
  input  logic [N_IN*N_OUT*DATA_W-1:0]   weights,
  input  logic [N_OUT*DATA_W-1:0]        biases,
  output logic [N_OUT*DATA_W-1:0]        out_vec,
  output logic                           busy,
  output logic                           done
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  logic [2:0]                 r_state;
  logic [IW-1:0]              r_i;
  logic [OW-1:0]              r_o;
  logic signed [DATA_W-1:0]   r_in   [N_IN];
  logic signed [DATA_W-1:0]   r_bias [N_OUT];
  logic signed [DATA_W-1:0]   r_out  [N_OUT];
  logic signed [2*DATA_W-1:0] r_prod;
  logic signed [ACC_W-1:0]    r_acc;

  logic signed [DATA_W-1:0]   w_in   [N_IN];
  logic signed [DATA_W-1:0]   w_bias [N_OUT];
  logic signed [DATA_W-1:0]   w_w    [N_OUT][N_IN];
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_shr;
  logic signed [DATA_W-1:0]   w_res;

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    assign w_in[g] = in_vec[g*DATA_W +: DATA_W];
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign w_bias[g]                   = biases[g*DATA_W +: DATA_W];
    assign out_vec[g*DATA_W +: DATA_W] = r_out[g];
    for (genvar h = 0; h < N_IN; h++) begin : g_w
      assign w_w[g][h] = weights[(g*N_IN + h)*DATA_W +: DATA_W];
    end
  end

  // Operands are sign-extended to full product width before the multiply.
  assign w_prod = (2*DATA_W)'(r_in[r_i]) * (2*DATA_W)'(w_w[r_o][r_i]);
  assign w_sum  = r_acc + (ACC_W'(r_bias[r_o]) <<< FRAC_W);
  assign w_shr  = w_sum >>> FRAC_W;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_res = w_shr[DATA_W-1:0];
    if (w_shr > SAT_MAX)      w_res = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shr < SAT_MIN) w_res = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef FC_RELU_EN
    if (w_res[DATA_W-1]) w_res = '0;
`endif
  end

  // NOTE: operand snapshots carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_in   <= w_in;
      r_bias <= w_bias;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_o     <= '0;
      r_prod  <= '0;
      r_acc   <= '0;
      for (int k = 0; k < N_OUT; k++) r_out[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_prod  <= '0;
            r_i     <= '0;
            r_o     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_prod <= w_prod;
          r_acc  <= r_acc + ACC_W'(r_prod);
          if (r_i == IW'(N_IN-1)) r_state <= S_DRAIN;
          else                    r_i     <= r_i + 1'b1;
        end
        S_DRAIN: begin
          r_acc   <= r_acc + ACC_W'(r_prod);
          r_state <= S_FINAL;
        end
        S_FINAL: begin
          r_out[r_o] <= w_res;
          r_acc      <= '0;
          r_prod     <= '0;
          r_i        <= '0;
          if (r_o == OW'(N_OUT-1)) begin
            r_state <= S_DONE;
          end else begin
            r_o     <= r_o + 1'b1;
            r_state <= S_MAC;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_MAC) || (r_state == S_DRAIN) || (r_state == S_FINAL);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_fc_layer_pipe.sv
// Self-checking bench for fc_layer_pipe: a reference model fills a scoreboard when a run starts,
// and the scoreboard is drained against out_vec when done pulses.
module tb_fc_layer_pipe;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int N_IN   = 5;
  localparam int N_OUT  = 3;
  localparam int LAT    = N_OUT*(N_IN+2) + 1;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         start;
  logic [N_IN*DATA_W-1:0]       in_vec;
  logic [N_IN*N_OUT*DATA_W-1:0] weights;
  logic [N_OUT*DATA_W-1:0]      biases;
  logic [N_OUT*DATA_W-1:0]      out_vec;
  logic                         busy;
  logic                         done;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  fc_layer_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .reset(reset), .start(start), .in_vec(in_vec), .weights(weights),
    .biases(biases), .out_vec(out_vec), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model(input int o);
    longint acc;
    logic [DATA_W-1:0] r;
    acc = 0;
    for (int i = 0; i < N_IN; i++)
      acc += longint'($signed(in_vec[i*DATA_W +: DATA_W])) *
             longint'($signed(weights[(o*N_IN + i)*DATA_W +: DATA_W]));
    acc += longint'($signed(biases[o*DATA_W +: DATA_W])) * (longint'(1) <<< FRAC_W);
    acc = acc >>> FRAC_W;
    if (acc > 32767)       acc = 32767;
    else if (acc < -32768) acc = -32768;
`ifdef FC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    r = acc[DATA_W-1:0];
    return r;
  endfunction

  task automatic push_expected();
    for (int o = 0; o < N_OUT; o++) exp_q.push_back(model(o));
  endtask

  task automatic fill(input logic [DATA_W-1:0] iv, input logic [DATA_W-1:0] wv, input logic [DATA_W-1:0] bv);
    for (int i = 0; i < N_IN; i++) in_vec[i*DATA_W +: DATA_W] = iv;
    for (int k = 0; k < N_IN*N_OUT; k++) weights[k*DATA_W +: DATA_W] = wv;
    for (int o = 0; o < N_OUT; o++) biases[o*DATA_W +: DATA_W] = bv;
  endtask

  task automatic compare_outputs(input string tag);
    logic [DATA_W-1:0] e;
    for (int o = 0; o < N_OUT; o++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("%s_sb_empty%0d", tag, o), 64'(exp_q.size()), 64'(1));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_out%0d", tag, o), 64'(out_vec[o*DATA_W +: DATA_W]), 64'(e));
      end
    end
  endtask

  // One evaluation; poke_at pulses start and corrupts in_vec/biases at that cycle, reset_at aborts.
  task automatic run(input string tag, input int poke_at, input int reset_at);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clk);
      start = (n == poke_at);
      if (n == poke_at) begin
        in_vec = ~in_vec;
        biases = ~biases;
      end
      if (n < LAT) begin
        check($sformatf("%s_busy_c%0d", tag, n), 64'(busy), 64'(1));
        check($sformatf("%s_done_c%0d", tag, n), 64'(done), 64'(0));
      end else begin
        check($sformatf("%s_done_at_lat", tag), 64'(done), 64'(1));
        check($sformatf("%s_busy_at_lat", tag), 64'(busy), 64'(0));
        compare_outputs(tag);
      end
      if (n == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check($sformatf("%s_rst_out", tag), 64'(out_vec), 64'(0));
        check($sformatf("%s_rst_busy", tag), 64'(busy), 64'(0));
        check($sformatf("%s_rst_done", tag), 64'(done), 64'(0));
        exp_q.delete();
        repeat (LAT) begin
          @(negedge clk);
          check($sformatf("%s_no_done_after_rst", tag), 64'(done), 64'(0));
        end
        return;
      end
    end
    @(negedge clk);
    check($sformatf("%s_done_one_cycle", tag), 64'(done), 64'(0));
    check($sformatf("%s_idle_busy", tag), 64'(busy), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill('0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", 64'(out_vec), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    reset = 1'b0;

    fill(16'h0100, 16'h0100, 16'h0000);
    run("unity", 0, 0);
    check("unity_lit0", 64'(out_vec[0 +: DATA_W]), 64'(16'h0500));

    fill(16'h0001, 16'h0080, 16'h0000);
    run("round_pos", 0, 0);
    check("round_pos_lit", 64'(out_vec[0 +: DATA_W]), 64'(16'h0002));
    fill(16'h0001, 16'hFF80, 16'h0000);
    run("round_neg", 0, 0);

    fill(16'h7F00, 16'h0200, 16'h0000);
    run("sat_pos", 0, 0);
    check("sat_pos_lit", 64'(out_vec[DATA_W +: DATA_W]), 64'(16'h7FFF));
    fill(16'h7F00, 16'hFE00, 16'h0000);
    run("sat_neg", 0, 0);

    fill(16'h0000, 16'h0123, 16'h0000);
    biases = {16'h0000, 16'h0180, 16'hFF00};
    run("bias_only", 0, 0);

    fill(16'h0180, 16'hFF40, 16'h0020);
    for (int k = 0; k < N_IN*N_OUT; k++) weights[k*DATA_W +: DATA_W] = 16'($urandom_range(0, 16'h0600)) - 16'h0300;
    run("mid_run", 5, 0);

    fill(16'h0100, 16'h0100, 16'h0000);
    run("abort", 0, 10);
    run("after_abort", 0, 0);

    // start held high: ignored in the DONE cycle, re-accepted from IDLE right after.
    for (int i = 0; i < N_IN; i++) in_vec[i*DATA_W +: DATA_W] = 16'($urandom_range(0, 16'h0400)) - 16'h0200;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    repeat (LAT) @(negedge clk);
    check("hold_done", 64'(done), 64'(1));
    compare_outputs("hold1");
    @(negedge clk);
    check("hold_idle_busy", 64'(busy), 64'(0));
    check("hold_idle_done", 64'(done), 64'(0));
    push_expected();
    @(negedge clk);
    check("hold_retrigger_busy", 64'(busy), 64'(1));
    start = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check("hold2_done", 64'(done), 64'(1));
    compare_outputs("hold2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
